// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive path.
//   uart_rx_entry_t  - one FIFO entry {brk, parity, data[8:0]}
//   rx_cap_state_e   - capture FSM state of uart_rx_fifo
//   Parity*          - parity-mode encodings shared with the receiver
package uart_pkg;

  localparam logic [1:0] ParitySpace = 2'b00;
  localparam logic [1:0] ParityOdd   = 2'b01;
  localparam logic [1:0] ParityEven  = 2'b10;
  localparam logic [1:0] ParityMark  = 2'b11;

  // 'break' is a keyword, so the break flag is stored as brk.
  typedef struct packed {
    logic       brk;
    logic       parity;
    logic [8:0] data;
  } uart_rx_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StGuard
  } rx_cap_state_e;

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: FIFO storage array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address
//   o_rd_data  read data (combinational)
module sync_fifo_ram #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned Width     = 11
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [AddrWidth-1:0] i_wr_addr,
  input  logic [Width-1:0]     i_wr_data,
  input  logic [AddrWidth-1:0] i_rd_addr,
  output logic [Width-1:0]     o_rd_data
);

  logic [Width-1:0] r_mem [2**AddrWidth];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind the UART receiver. Drains each frame
// from the receiver holding register via a one-cycle rxReceiveReq ack and
// stores {brk, parity, data} in a 2^DEPTH_LOG2 first-word-fall-through FIFO.
// Optional idle timeout enabled by macro UART_RX_FIFO_TIMEOUT_EN.
//   clk, rstN                    clock, async active-low reset
//   rxData/rxDataReceived/...    receiver side; rxReceiveReq is the ack
//   readReq/readData/...         host read port, head always visible
//   full, count, levelIrq        fill status (levelIrq vs. level threshold)
//   overflowSticky/clearOverflow lost-frame flag and its clear
//   timeoutIrq                   idle timeout (macro builds only)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [8:0]          rxData,
  input  logic                rxDataReceived,
  input  logic                rxParityError,
  input  logic                rxOverflow,
  input  logic                rxBreak,
  output logic                rxReceiveReq,
  input  logic                readReq,
  output logic [8:0]          readData,
  output logic                readParityError,
  output logic                readBreak,
  output logic                readValid,
  output logic                full,
  output logic [DEPTH_LOG2:0] count,
  input  logic [DEPTH_LOG2:0] level,
  output logic                levelIrq,
`ifdef UART_RX_FIFO_TIMEOUT_EN
  output logic                timeoutIrq,
`endif
  output logic                overflowSticky,
  input  logic                clearOverflow
);

  localparam int unsigned PtrW = DEPTH_LOG2 + 1;

  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH_LOG2 must be in 1..8");
  end
  if (TIMEOUT_CYCLES == 16'd0) begin : g_bad_timeout
    $error("uart_rx_fifo: TIMEOUT_CYCLES must be non-zero");
  end

  // Capture FSM
  rx_cap_state_e r_state, w_state_d;
  logic          w_capture;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (rxDataReceived || rxBreak) w_state_d = StAck;
      StAck:   w_state_d = StGuard;
      // Receiver drops its flags at the ack edge; skip one cycle of stale inputs.
      StGuard: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_capture    = 1'b0;
    rxReceiveReq = 1'b0;
    unique case (r_state)
      StIdle:  w_capture    = rxDataReceived || rxBreak;
      StAck:   rxReceiveReq = 1'b1;
      default: ;
    endcase
  end

  // Break without a data word becomes a break-only entry with zero data.
  uart_rx_entry_t w_entry;
  always_comb begin
    w_entry = '0;
    if (rxDataReceived) begin
      w_entry.brk    = rxBreak;
      w_entry.parity = rxParityError;
      w_entry.data   = rxData;
    end else begin
      w_entry.brk = 1'b1;
    end
  end

  // Pointers carry a wrap bit above the address.
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d, w_count_d;
  logic            w_empty, w_full, w_full_d, w_push, w_pop, w_drop;
  logic            r_full, r_level_irq, r_ovf;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                   (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
  assign w_pop   = readReq && !w_empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign w_push  = w_capture && (!w_full || w_pop);
  assign w_drop  = w_capture && !w_push;

  assign w_wr_ptr_d = r_wr_ptr + PtrW'(w_push);
  assign w_rd_ptr_d = r_rd_ptr + PtrW'(w_pop);
  assign w_count_d  = w_wr_ptr_d - w_rd_ptr_d;
  assign w_full_d   = (w_wr_ptr_d[DEPTH_LOG2-1:0] == w_rd_ptr_d[DEPTH_LOG2-1:0]) &&
                      (w_wr_ptr_d[DEPTH_LOG2] != w_rd_ptr_d[DEPTH_LOG2]);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_full      <= 1'b0;
      r_level_irq <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_full      <= w_full_d;
      r_level_irq <= (w_count_d >= level) && (level != '0);
      // Set wins over clear.
      r_ovf       <= w_drop || rxOverflow || (r_ovf && !clearOverflow);
    end
  end

  logic [$bits(uart_rx_entry_t)-1:0] w_head_raw;
  uart_rx_entry_t                    w_head;

  sync_fifo_ram #(
    .AddrWidth (DEPTH_LOG2),
    .Width     ($bits(uart_rx_entry_t))
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wr_data (w_entry),
    .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rd_data (w_head_raw)
  );

  // Mask the unreset array so the read port shows zero while empty.
  assign w_head          = w_empty ? '0 : uart_rx_entry_t'(w_head_raw);
  assign readData        = w_head.data;
  assign readParityError = w_head.parity;
  assign readBreak       = w_head.brk;
  assign readValid       = !w_empty;
  assign full            = r_full;
  assign count           = r_wr_ptr - r_rd_ptr;
  assign levelIrq        = r_level_irq;
  assign overflowSticky  = r_ovf;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] r_idle_cnt;
  logic        r_timeout_irq;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_idle_cnt    <= '0;
      r_timeout_irq <= 1'b0;
    end else if (w_push || w_pop || w_empty) begin
      r_idle_cnt    <= '0;
      r_timeout_irq <= 1'b0;
    end else if (r_idle_cnt != TIMEOUT_CYCLES) begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
      if (r_idle_cnt + 16'd1 == TIMEOUT_CYCLES) r_timeout_irq <= 1'b1;
    end
  end

  assign timeoutIrq = r_timeout_irq;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo at
// DEPTH_LOG2 = 2 (4 entries) and TIMEOUT_CYCLES = 10. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rstN;
  logic [8:0] rxData;
  logic       rxDataReceived;
  logic       rxParityError;
  logic       rxOverflow;
  logic       rxBreak;
  logic       rxReceiveReq;
  logic       readReq;
  logic [8:0] readData;
  logic       readParityError;
  logic       readBreak;
  logic       readValid;
  logic       full;
  logic [2:0] count;
  logic [2:0] level;
  logic       levelIrq;
  logic       overflowSticky;
  logic       clearOverflow;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic       timeoutIrq;
`endif

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_fifo #(
    .DEPTH_LOG2     (2),
    .TIMEOUT_CYCLES (16'd10)
  ) dut (
    .clk             (clk),
    .rstN            (rstN),
    .rxData          (rxData),
    .rxDataReceived  (rxDataReceived),
    .rxParityError   (rxParityError),
    .rxOverflow      (rxOverflow),
    .rxBreak         (rxBreak),
    .rxReceiveReq    (rxReceiveReq),
    .readReq         (readReq),
    .readData        (readData),
    .readParityError (readParityError),
    .readBreak       (readBreak),
    .readValid       (readValid),
    .full            (full),
    .count           (count),
    .level           (level),
    .levelIrq        (levelIrq),
`ifdef UART_RX_FIFO_TIMEOUT_EN
    .timeoutIrq      (timeoutIrq),
`endif
    .overflowSticky  (overflowSticky),
    .clearOverflow   (clearOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  // Receiver model: presents a frame, drops it when it sees the ack.
  task automatic send_frame(input logic [8:0] d, input logic par, input logic brk,
                            input logic dv);
    @(negedge clk);
    rxData = d; rxParityError = par; rxBreak = brk; rxDataReceived = dv;
    @(negedge clk);
    check_eq("ack_n1", 32'(rxReceiveReq), 1);
    rxData = '0; rxParityError = 1'b0; rxBreak = 1'b0; rxDataReceived = 1'b0;
    @(negedge clk);
    check_eq("ack_n2", 32'(rxReceiveReq), 0);
  endtask

  task automatic pop();
    @(negedge clk);
    readReq = 1'b1;
    @(negedge clk);
    readReq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rstN = 1'b0; rxData = '0; rxDataReceived = 1'b0; rxParityError = 1'b0;
    rxOverflow = 1'b0; rxBreak = 1'b0; readReq = 1'b0; level = 3'd0;
    clearOverflow = 1'b0;
    do_reset();

    // Reset state
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_valid", 32'(readValid), 0);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_ack", 32'(rxReceiveReq), 0);
    check_eq("rst_ovf", 32'(overflowSticky), 0);
    check_eq("rst_lvl", 32'(levelIrq), 0);
    check_eq("rst_data", 32'(readData), 0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    check_eq("rst_tmo", 32'(timeoutIrq), 0);
`endif

    // Single frame, with count/head checked in the ack cycle
    @(negedge clk);
    rxData = 9'h055; rxDataReceived = 1'b1;
    @(negedge clk);
    check_eq("sf_ack", 32'(rxReceiveReq), 1);
    check_eq("sf_count_n1", 32'(count), 1);
    check_eq("sf_valid_n1", 32'(readValid), 1);
    check_eq("sf_data", 32'(readData), 'h055);
    check_eq("sf_par", 32'(readParityError), 0);
    rxDataReceived = 1'b0; rxData = '0;
    @(negedge clk);
    check_eq("sf_ack_off", 32'(rxReceiveReq), 0);
    pop();
    check_eq("sf_count_pop", 32'(count), 0);
    check_eq("sf_valid_pop", 32'(readValid), 0);

    // Pop while empty is ignored
    pop();
    check_eq("ep_count", 32'(count), 0);

    // Push and readReq together while empty: push lands, pop ignored
    @(negedge clk);
    rxData = 9'h1AB; rxDataReceived = 1'b1; readReq = 1'b1;
    @(negedge clk);
    readReq = 1'b0; rxDataReceived = 1'b0; rxData = '0;
    check_eq("pe_count", 32'(count), 1);
    check_eq("pe_data", 32'(readData), 'h1AB);
    @(negedge clk);
    pop();

    // Parity flag travels with the data
    send_frame(9'h100, 1'b1, 1'b0, 1'b1);
    check_eq("par_flag", 32'(readParityError), 1);
    check_eq("par_data", 32'(readData), 'h100);
    check_eq("par_brk", 32'(readBreak), 0);
    pop();

    // Fill with level = 3: frames 1..4 fit, frame 5 is dropped
    level = 3'd3;
    for (int i = 1; i <= 4; i++) begin
      send_frame(9'(i), 1'b0, 1'b0, 1'b1);
      check_eq("fill_count", 32'(count), 32'(i));
      check_eq("fill_full", 32'(full), 32'(i == 4));
      check_eq("fill_lvl", 32'(levelIrq), 32'(i >= 3));
      check_eq("fill_ovf", 32'(overflowSticky), 0);
    end
    send_frame(9'd5, 1'b0, 1'b0, 1'b1);
    check_eq("ovf_count", 32'(count), 4);
    check_eq("ovf_set", 32'(overflowSticky), 1);
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain_data", 32'(readData), 32'(i));
      check_eq("drain_valid", 32'(readValid), 1);
      pop();
    end
    check_eq("drain_count", 32'(count), 0);
    check_eq("drain_full", 32'(full), 0);
    check_eq("drain_lvl", 32'(levelIrq), 0);
    check_eq("drain_data0", 32'(readData), 0);
    check_eq("ovf_held", 32'(overflowSticky), 1);
    @(negedge clk); clearOverflow = 1'b1;
    @(negedge clk); clearOverflow = 1'b0;
    check_eq("ovf_clr", 32'(overflowSticky), 0);
    // Set and clear together: set wins
    @(negedge clk); clearOverflow = 1'b1; rxOverflow = 1'b1;
    @(negedge clk); clearOverflow = 1'b0; rxOverflow = 1'b0;
    check_eq("ovf_setwin", 32'(overflowSticky), 1);
    @(negedge clk); clearOverflow = 1'b1;
    @(negedge clk); clearOverflow = 1'b0;
    check_eq("ovf_clr2", 32'(overflowSticky), 0);

    // Break-only entry, exactly one ack
    level = 3'd0;
    acks = 0;
    @(negedge clk);
    rxBreak = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rxReceiveReq) begin
        acks++;
        rxBreak = 1'b0;
      end
    end
    rxBreak = 1'b0;
    check_eq("brk_acks", 32'(acks), 1);
    check_eq("brk_count", 32'(count), 1);
    check_eq("brk_flag", 32'(readBreak), 1);
    check_eq("brk_data", 32'(readData), 0);
    check_eq("brk_par", 32'(readParityError), 0);
    pop();

    // Push+pop at full over 20 frames; level = 0 keeps levelIrq low
    for (int k = 0; k < 4; k++) send_frame(9'(k), 1'b0, 1'b0, 1'b1);
    check_eq("wrap_full0", 32'(full), 1);
    for (int k = 4; k < 20; k++) begin
      @(negedge clk);
      check_eq("wrap_head", 32'(readData), 32'(k - 4));
      rxData = 9'(k); rxDataReceived = 1'b1; readReq = 1'b1;
      @(negedge clk);
      readReq = 1'b0; rxDataReceived = 1'b0; rxData = '0;
      check_eq("wrap_count", 32'(count), 4);
      check_eq("wrap_ack", 32'(rxReceiveReq), 1);
      @(negedge clk);
      check_eq("wrap_full", 32'(full), 1);
      check_eq("wrap_ovf", 32'(overflowSticky), 0);
    end
    check_eq("wrap_lvl0", 32'(levelIrq), 0);
    for (int k = 16; k < 20; k++) begin
      check_eq("wrap_tail", 32'(readData), 32'(k));
      pop();
    end
    check_eq("wrap_empty", 32'(readValid), 0);

    // Reset asserted during the ack cycle
    level = 3'd1;
    @(negedge clk); rxOverflow = 1'b1;
    @(negedge clk); rxOverflow = 1'b0;
    @(negedge clk);
    rxData = 9'h0AA; rxDataReceived = 1'b1;
    @(negedge clk);
    check_eq("ra_ack", 32'(rxReceiveReq), 1);
    check_eq("ra_lvl", 32'(levelIrq), 1);
    rstN = 1'b0; rxDataReceived = 1'b0; rxData = '0;
    #1;
    check_eq("ra_ack0", 32'(rxReceiveReq), 0);
    check_eq("ra_count", 32'(count), 0);
    check_eq("ra_valid", 32'(readValid), 0);
    check_eq("ra_data", 32'(readData), 0);
    check_eq("ra_ovf", 32'(overflowSticky), 0);
    check_eq("ra_lvl0", 32'(levelIrq), 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    send_frame(9'h0CC, 1'b0, 1'b0, 1'b1);
    check_eq("ra_next_data", 32'(readData), 'h0CC);
    check_eq("ra_next_count", 32'(count), 1);
    pop();

`ifdef UART_RX_FIFO_TIMEOUT_EN
    // One frame, no reads: timeout on the 10th edge after the push edge
    @(negedge clk);
    rxData = 9'h033; rxDataReceived = 1'b1;
    @(negedge clk);
    rxDataReceived = 1'b0; rxData = '0;
    repeat (9) @(negedge clk);
    check_eq("tmo_early", 32'(timeoutIrq), 0);
    @(negedge clk);
    check_eq("tmo_set", 32'(timeoutIrq), 1);
    repeat (3) @(negedge clk);
    check_eq("tmo_hold", 32'(timeoutIrq), 1);
    pop();
    check_eq("tmo_clr", 32'(timeoutIrq), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
